// File: rtl/ex_muldiv_unit.sv
// Multi-cycle multiply/divide unit for the EX stage; owns HI/LO and stalls the front end while busy.
// Optional divider: define MULDIV_DIVIDE_EN to build DIV/DIVU support.
module ex_muldiv_unit #(
    parameter int NBits = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic             Flush,
    input  logic [NBits-1:0] ReadData1,
    input  logic [NBits-1:0] ReadData2,
    input  logic [1:0]       ForwardA,
    input  logic [1:0]       ForwardB,
    input  logic [NBits-1:0] ALUMemOrPCData,
    input  logic [NBits-1:0] MEM_ALUResult,
    output logic             Stall,
    output logic             Done,
    output logic             DivByZero,
    output logic [NBits-1:0] HI,
    output logic [NBits-1:0] LO,
    output logic [NBits-1:0] MoveResult
);
    localparam int CW = $clog2(NBits);
    localparam logic [CW-1:0] CNT_INIT = CW'(NBits - 1);
    localparam logic [2:0] OP_MTHI = 3'b010;
    localparam logic [2:0] OP_MTLO = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
`ifdef MULDIV_DIVIDE_EN
        DIV,
`endif
        FIX,
        DONE
    } state_t;

    state_t             state, state_next;
    logic [CW-1:0]      cnt;
    logic [NBits-1:0]   op_a, op_b, abs_a, abs_b, mag_a, mag_b, hi_r, lo_r;
    logic [2*NBits-1:0] acc, prod_fix;
    logic [NBits:0]     mul_sum;
    logic               res_neg, done_r;
    logic               is_mul_op, is_long_op, op_signed, a_neg, b_neg;

    always_comb begin
        case (ForwardA)
            2'b01:   op_a = ALUMemOrPCData;
            2'b10:   op_a = MEM_ALUResult;
            default: op_a = ReadData1;
        endcase
        case (ForwardB)
            2'b01:   op_b = ALUMemOrPCData;
            2'b10:   op_b = MEM_ALUResult;
            default: op_b = ReadData2;
        endcase
    end

    assign is_mul_op = Op[2] & ~Op[1];
    assign op_signed = ~Op[0];
    assign a_neg     = op_signed & op_a[NBits-1];
    assign b_neg     = op_signed & op_b[NBits-1];
    assign abs_a     = a_neg ? -op_a : op_a;
    assign abs_b     = b_neg ? -op_b : op_b;

    // Shift-add: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
    assign mul_sum  = {1'b0, acc[2*NBits-1:NBits]} + (acc[0] ? {1'b0, mag_a} : {(NBits+1){1'b0}});
    assign prod_fix = res_neg ? -acc : acc;

`ifdef MULDIV_DIVIDE_EN
    logic               is_div_op, is_div_r, rem_neg, dbz_r;
    logic [NBits:0]     div_trial;
    logic [2*NBits-1:0] div_next;
    logic [NBits-1:0]   quo_fix, rem_fix;

    assign is_div_op  = Op[2] & Op[1];
    assign is_long_op = is_mul_op | is_div_op;
    // acc holds {remainder, dividend/quotient}; the trial uses the shifted remainder with its carry-out bit.
    assign div_trial  = acc[2*NBits-1:NBits-1] - {1'b0, mag_b};
    assign div_next   = div_trial[NBits] ? {acc[2*NBits-2:0], 1'b0}
                                         : {div_trial[NBits-1:0], acc[NBits-2:0], 1'b1};
    assign quo_fix    = res_neg ? -acc[NBits-1:0] : acc[NBits-1:0];
    assign rem_fix    = rem_neg ? -acc[2*NBits-1:NBits] : acc[2*NBits-1:NBits];
    assign DivByZero  = dbz_r;
`else
    assign is_long_op = is_mul_op;
    assign DivByZero  = 1'b0;
`endif

    always_comb begin
        state_next = state;
        Stall      = 1'b0;
        case (state)
            IDLE: begin
                Stall = Start & is_long_op;
                if (Start && is_mul_op) state_next = MUL;
`ifdef MULDIV_DIVIDE_EN
                else if (Start && is_div_op) state_next = DIV;
`endif
            end
            MUL: begin
                Stall = 1'b1;
                if (cnt == '0) state_next = FIX;
            end
`ifdef MULDIV_DIVIDE_EN
            DIV: begin
                Stall = 1'b1;
                if (cnt == '0) state_next = FIX;
            end
`endif
            FIX: begin
                Stall      = 1'b1;
                state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (Flush) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            acc     <= '0;
            res_neg <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
            done_r  <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
            is_div_r <= 1'b0;
            rem_neg  <= 1'b0;
            dbz_r    <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            done_r <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
            dbz_r  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (Start && !Flush) begin
                        if (is_long_op) begin
                            cnt     <= CNT_INIT;
                            mag_a   <= abs_a;
                            mag_b   <= abs_b;
                            acc     <= {{NBits{1'b0}}, is_mul_op ? abs_b : abs_a};
                            res_neg <= a_neg ^ b_neg;
`ifdef MULDIV_DIVIDE_EN
                            is_div_r <= is_div_op;
                            rem_neg  <= a_neg;
`endif
                        end else if (Op == OP_MTHI) begin
                            hi_r <= op_a;
                        end else if (Op == OP_MTLO) begin
                            lo_r <= op_a;
                        end
                    end
                end
                MUL: begin
                    acc <= {mul_sum, acc[NBits-1:1]};
                    cnt <= cnt - CW'(1);
                end
`ifdef MULDIV_DIVIDE_EN
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt - CW'(1);
                end
`endif
                FIX: begin
                    if (!Flush) begin
`ifdef MULDIV_DIVIDE_EN
                        if (is_div_r) begin
                            hi_r  <= rem_fix;
                            lo_r  <= quo_fix;
                            dbz_r <= (mag_b == '0);
                        end else begin
                            {hi_r, lo_r} <= prod_fix;
                        end
`else
                        {hi_r, lo_r} <= prod_fix;
`endif
                        done_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Done       = done_r;
    assign HI         = hi_r;
    assign LO         = lo_r;
    assign MoveResult = Op[0] ? lo_r : hi_r;
endmodule
